// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared types and constants for the 7-segment scan controller.
//   nibble_t : one hex digit value
//   SEG_OFF  : all segments dark (active-low), 7'h7F
//   HEX_SEG  : hex-to-segment table, bit order {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
package seg7_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Purely combinational hex nibble to 7-segment lookup (active-low segments).
// Ports:
//   nibble in  4 : hex value 0..F
//   seg    out 7 : segments {g,f,e,d,c,b,a}, 0 = lit
// -----------------------------------------------------------------------------
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexed scan of N_DIGITS common-anode digits sharing one segment
// bus. Digit data is double-buffered: `load` writes the pending buffer and the
// displayed (active) buffer is refreshed only at frame boundaries, so a frame
// is never torn. Each slot starts with BLANK_CYCLES of anode-off time to
// suppress ghosting. All outputs are registered and active-low.
//
// Ports:
//   clk        in  1          : system clock
//   rst_n      in  1          : asynchronous active-low reset
//   load       in  1          : strobe, captures digits_in (and dp_in)
//   digits_in  in  4*N_DIGITS : nibble i drives digit i, nibble 0 in LSBs
//   digit_en   in  N_DIGITS   : live per-digit enable mask
//   an         out N_DIGITS   : one-hot active-low anode select, all 1s = off
//   seg        out 7          : segments {g,f,e,d,c,b,a}, active-low
//   frame_done out 1          : one-cycle pulse after the last slot of a frame
//   dp_in      in  N_DIGITS   : decimal points (only with SEG7_DP_EN)
//   dp         out 1          : decimal point, active-low (only with SEG7_DP_EN)
//
// Build option: define SEG7_DP_EN to add the double-buffered decimal point.
// -----------------------------------------------------------------------------
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  frame_done
`ifdef SEG7_DP_EN
  ,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic                  dp
`endif
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  nibble_t [N_DIGITS-1:0]  pending;
  nibble_t [N_DIGITS-1:0]  active;

  logic       tick;
  logic       frame_end;
  logic       lit;
  logic [6:0] cur_seg;

  assign tick      = (cnt == CNT_W'(SCAN_DIV - 1));
  assign frame_end = tick && (idx == IDX_W'(N_DIGITS - 1));
  // A disabled digit still consumes its slot so every digit keeps equal duty.
  assign lit       = (cnt >= CNT_W'(BLANK_CYCLES)) && digit_en[idx];

  seg7_hex_decode u_dec (
    .nibble (active[idx]),
    .seg    (cur_seg)
  );

  // Slot counter and digit index.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Double buffer. A load on the boundary cycle bypasses pending so the new
  // value is shown in the very next frame rather than one frame later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      active  <= '0;
    end else begin
      if (load)      pending <= digits_in;
      if (frame_end) active  <= load ? digits_in : pending;
    end
  end

  // Output register stage: one cycle behind cnt/idx. Reset forces the
  // display dark asynchronously, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= '1;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      an         <= lit ? ~(N_DIGITS'(1) << idx) : '1;
      seg        <= lit ? cur_seg : SEG_OFF;
      frame_done <= frame_end;
    end
  end

`ifdef SEG7_DP_EN
  logic [N_DIGITS-1:0] dp_pending;
  logic [N_DIGITS-1:0] dp_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_pending <= '0;
      dp_active  <= '0;
      dp         <= 1'b1;
    end else begin
      if (load)      dp_pending <= dp_in;
      if (frame_end) dp_active  <= load ? dp_in : dp_pending;
      dp <= lit ? ~dp_active[idx] : 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Self-checking bench for seg7_scan_ctrl with N_DIGITS=4, SCAN_DIV=4,
// BLANK_CYCLES=1 (16-cycle frame). A frame/slot position model predicts the
// outputs on every cycle; directed literal checks pin specific cycles.
// Optional: define SEG7_DP_EN to exercise the decimal point.
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = N * DIV;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic [15:0]  digits_in;
  logic [3:0]   digit_en;
  logic [3:0]   an;
  logic [6:0]   seg;
  logic         frame_done;
`ifdef SEG7_DP_EN
  logic [3:0]   dp_in;
  logic         dp;
`endif

  int checks   = 0;
  int failures = 0;

  seg7_scan_ctrl #(
    .N_DIGITS     (N),
    .SCAN_DIV     (DIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .digits_in  (digits_in),
    .digit_en   (digit_en),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
`ifdef SEG7_DP_EN
    ,
    .dp_in      (dp_in),
    .dp         (dp)
`endif
  );

  always #5 clk = ~clk;

  // Reference segment patterns, written out independently of the design.
  logic [6:0] ref_seg [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: the k-th clock edge after reset release sits at frame position
  // k mod 16; the registered outputs after that edge show slot (pos/4) at
  // offset (pos%4). Frame f displays the most recent load taken at or before
  // the last edge of frame f-1 (zero if none since reset).
  // ---------------------------------------------------------------------------
  int          k;
  logic [15:0] latest, shown;
  logic [3:0]  latest_dp, shown_dp;

  always begin
    int pos, c, i;
    logic lit;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_fd, e_dp;
    @(posedge clk);
    if (!rst_n) begin
      k = 0; latest = '0; shown = '0; latest_dp = '0; shown_dp = '0;
      #1;
      check("rst_an", an, 4'hF);
      check("rst_seg", seg, 7'h7F);
      check("rst_fd", frame_done, 1'b0);
    end else begin
      pos   = k % FRAME;
      c     = pos % DIV;
      i     = pos / DIV;
      lit   = (c >= BLANK) && digit_en[i];
      e_an  = lit ? (4'hF & ~(4'b0001 << i)) : 4'hF;
      e_seg = lit ? ref_seg[shown[i*4 +: 4]] : 7'h7F;
      e_fd  = (pos == FRAME - 1);
      e_dp  = lit ? ~shown_dp[i] : 1'b1;
      if (load) begin
        latest = digits_in;
`ifdef SEG7_DP_EN
        latest_dp = dp_in;
`endif
      end
      if (pos == FRAME - 1) begin
        shown    = latest;
        shown_dp = latest_dp;
      end
      k++;
      #1;
      if (rst_n) begin
        check("model_an", an, e_an);
        check("model_seg", seg, e_seg);
        check("model_fd", frame_done, e_fd);
`ifdef SEG7_DP_EN
        check("model_dp", dp, e_dp);
`else
        if (e_dp !== e_dp) check("dp_unused", 1'b0, 1'b1);
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus. Inputs change on falling edges; m counts falling edges
  // since reset release, so after goto(s) the outputs show position s.
  // ---------------------------------------------------------------------------
  int m;

  task automatic goto(input int s);
    while (m - 1 < s) begin
      @(negedge clk);
      m++;
    end
  endtask

  initial begin
    int pulses, first_pulse;
    load = 1'b0; digits_in = '0; digit_en = 4'hF;
`ifdef SEG7_DP_EN
    dp_in = '0;
`endif
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // 1. Reset hold and first lit slot.
    repeat (3) @(negedge clk);
    check("t1_hold_an", an, 4'hF);
    check("t1_hold_seg", seg, 7'h7F);
    rst_n = 1'b1;
    m = 0;
    goto(0);
    check("t1_blank_an", an, 4'hF);
    goto(1);
    check("t1_first_an", an, 4'hE);
    check("t1_first_seg", seg, 7'h40);

    // 2. Mid-frame load: current frame unchanged, next frame shows 1234.
    load = 1'b1; digits_in = 16'h1234;
    goto(2);
    load = 1'b0;
    goto(5);
    check("t2_same_an", an, 4'hD);
    check("t2_same_seg", seg, 7'h40);
    goto(16);
    check("t2_blank_an", an, 4'hF);
    goto(17); check("t2_d0_an", an, 4'hE); check("t2_d0_seg", seg, 7'h19);
    goto(19); check("t2_d0_end", seg, 7'h19);
    goto(20); check("t2_d1_blank", an, 4'hF);
    goto(21); check("t2_d1_an", an, 4'hD); check("t2_d1_seg", seg, 7'h30);
    goto(25); check("t2_d2_an", an, 4'hB); check("t2_d2_seg", seg, 7'h24);
    goto(29); check("t2_d3_an", an, 4'h7); check("t2_d3_seg", seg, 7'h79);

    // 3. Load on the exact boundary edge goes straight to the display.
    goto(30);
    load = 1'b1; digits_in = 16'h8888;
    goto(31);
    load = 1'b0;
    check("t3_fd", frame_done, 1'b1);
    goto(33);
    check("t3_an", an, 4'hE);
    check("t3_seg", seg, 7'h00);

    // 4. Digit 2 masked: dark for its whole slot, others unaffected.
    goto(35);
    digit_en = 4'b1011;
    goto(37); check("t4_d1_an", an, 4'hD); check("t4_d1_seg", seg, 7'h00);
    for (int s = 40; s <= 43; s++) begin
      goto(s);
      check("t4_mask_an", an, 4'hF);
      check("t4_mask_seg", seg, 7'h7F);
    end
    goto(45); check("t4_d3_an", an, 4'h7); check("t4_d3_seg", seg, 7'h00);
    goto(47);
    digit_en = 4'hF;

    // 6. Frame marker period and decimal point.
    goto(49);
    load = 1'b1; digits_in = 16'h5A0F;
`ifdef SEG7_DP_EN
    dp_in = 4'b0010;
`endif
    goto(50);
    load = 1'b0;
    pulses = 0; first_pulse = -1;
    for (int s = 52; s <= 115; s++) begin
      goto(s);
      if (frame_done) begin
        pulses++;
        if (first_pulse < 0) first_pulse = s;
      end
      if (s == 65) begin check("t6_d0_an", an, 4'hE); check("t6_d0_seg", seg, 7'h0E); end
      if (s == 69) check("t6_d1_seg", seg, 7'h40);
`ifdef SEG7_DP_EN
      if (s == 68) check("t6_dp_blank", dp, 1'b1);
      if (s == 69 || s == 70 || s == 71) check("t6_dp_lit", dp, 1'b0);
      if (s == 65 || s == 73 || s == 77) check("t6_dp_other", dp, 1'b1);
`endif
    end
    check("t6_pulses", pulses, 4);
    check("t6_first", first_pulse, 63);

    // 5. Asynchronous reset during the lit digit-2 slot.
    goto(121);
    check("t5_pre_an", an, 4'hB);
    check("t5_pre_seg", seg, 7'h08);
    rst_n = 1'b0;
    #1;
    check("t5_async_an", an, 4'hF);
    check("t5_async_seg", seg, 7'h7F);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m = 0;
    goto(1);
    check("t5_restart_an", an, 4'hE);
    check("t5_restart_seg", seg, 7'h40);
    goto(17);
    check("t5_cleared_seg", seg, 7'h40);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
